// File: rtl/alarm_scheduler_if.sv
// Purpose : bundles the alarm_scheduler control/status signals (time, config, user pulses, ring/game outputs).
// Latency : none; wires only.
// Backpr. : none; all inputs are single-cycle pulses or levels sampled every cycle.
// Ports   : slave = scheduler side (time/config/buttons in, ring/game/pending/missed out); master = driver side.
interface alarm_scheduler_if #(
   parameter int NUM_ALARMS = 4
) ();
   localparam int IW = $clog2(NUM_ALARMS);

   logic                  tick_1s;
   logic [15:0]           cur_time;
   logic                  cfg_we;
   logic [IW-1:0]         cfg_idx;
   logic [15:0]           cfg_time;
   logic                  cfg_en;
   logic                  button;
   logic                  snooze_btn;
   logic                  minigame_done;
   logic                  alarm_ringing;
   logic                  minigame_enable;
   logic [IW-1:0]         active_idx;
   logic [NUM_ALARMS-1:0] pending;
   logic                  missed;

   modport slave (
      input  tick_1s, cur_time, cfg_we, cfg_idx, cfg_time, cfg_en,
             button, snooze_btn, minigame_done,
      output alarm_ringing, minigame_enable, active_idx, pending, missed
   );

   modport master (
      output tick_1s, cur_time, cfg_we, cfg_idx, cfg_time, cfg_en,
             button, snooze_btn, minigame_done,
      input  alarm_ringing, minigame_enable, active_idx, pending, missed
   );
endinterface

// File: rtl/alarm_scheduler.sv
// Purpose : multi-slot BCD mm:ss alarm matcher; arbitrates pending slots onto one RING -> GAME path.
// Latency : match tick -> pending (1 clk) -> RING state (1 clk) -> alarm_ringing (1 clk); all outputs registered.
// Backpr. : none; button/snooze/done pulses outside their state are ignored, snooze beyond MAX_SNOOZE ignored.
// Ports   : MCLK, RESET_N (async active-low); s_if slave modport carries tick_1s, cur_time, cfg_*,
//           button, snooze_btn, minigame_done in and alarm_ringing, minigame_enable, active_idx, pending, missed out.
module alarm_scheduler #(
   parameter int NUM_ALARMS   = 4,
   parameter int SNOOZE_MIN   = 5,
   parameter int MAX_SNOOZE   = 3,
   parameter int RING_TIMEOUT = 60
) (
   input logic               MCLK,
   input logic               RESET_N,
   alarm_scheduler_if.slave  s_if
);
   localparam int IW = $clog2(NUM_ALARMS);

   typedef enum logic [1:0] {S_IDLE, S_RING, S_GAME} state_t;

   state_t                r_state;
   logic [15:0]           r_slot_time [NUM_ALARMS];
   logic [NUM_ALARMS-1:0] r_slot_en;
   logic [NUM_ALARMS-1:0] r_pending;
   logic [IW-1:0]         r_active;
   logic [IW-1:0]         r_active_idx;
   logic [3:0]            r_snz_cnt;
   logic [7:0]            r_tcnt;
   logic                  r_ringing;
   logic                  r_game;
   logic                  r_missed;

   logic                  w_cfg_ok;
   logic                  w_kill;
   logic [7:0]            w_tcnt_inc;
   logic                  w_snz_ok;
   logic                  w_ring;
   logic                  w_do_button;
   logic                  w_do_snooze;
   logic                  w_do_timeout;
   logic [15:0]           w_act_time;
   logic [4:0]            w_ones_sum;
   logic                  w_carry;
   logic [3:0]            w_ones;
   logic [3:0]            w_tens;
   logic [15:0]           w_snz_time;
   logic [NUM_ALARMS-1:0] w_pend_nxt;
   logic [IW-1:0]         w_sel;

   function automatic logic bcd_ok(input logic [15:0] t);
      return (t[15:12] <= 4'd5) && (t[11:8] <= 4'd9) && (t[7:4] <= 4'd5) && (t[3:0] <= 4'd9);
   endfunction

   assign w_cfg_ok   = s_if.cfg_we && bcd_ok(s_if.cfg_time);
   // Disabling the slot that is ringing abandons the episode silently.
   assign w_kill     = (r_state == S_RING) && w_cfg_ok && !s_if.cfg_en && (s_if.cfg_idx == r_active);
   assign w_tcnt_inc = r_tcnt + 8'd1;
   assign w_snz_ok   = s_if.snooze_btn && (r_snz_cnt < 4'(MAX_SNOOZE));

   // RING exits in priority order; a refused snooze falls through to the timeout test.
   assign w_ring       = (r_state == S_RING) && !w_kill;
   assign w_do_button  = w_ring && s_if.button;
   assign w_do_snooze  = w_ring && !s_if.button && w_snz_ok;
   assign w_do_timeout = w_ring && !s_if.button && !w_snz_ok && s_if.tick_1s &&
                         (w_tcnt_inc == 8'(RING_TIMEOUT));

   // Minutes + SNOOZE_MIN in BCD; SNOOZE_MIN <= 9 so at most one carry into the tens digit.
   assign w_act_time = r_slot_time[r_active];
   assign w_ones_sum = {1'b0, w_act_time[11:8]} + 5'(SNOOZE_MIN);
   assign w_carry    = (w_ones_sum > 5'd9);
   assign w_ones     = w_carry ? 4'(w_ones_sum - 5'd10) : w_ones_sum[3:0];
   assign w_tens     = (w_act_time[15:12] + {3'b000, w_carry} == 4'd6) ? 4'd0
                                                                     : w_act_time[15:12] + {3'b000, w_carry};
   assign w_snz_time = {w_tens, w_ones, w_act_time[7:0]};

   // Clear beats set on the same slot in the same cycle.
   always_comb begin
      w_pend_nxt = r_pending;
      for (int i = 0; i < NUM_ALARMS; i++) begin
         if (s_if.tick_1s && r_slot_en[i] && (r_slot_time[i] == s_if.cur_time) &&
             !((r_state != S_IDLE) && (r_active == IW'(i))))
            w_pend_nxt[i] = 1'b1;
         if ((w_cfg_ok && !s_if.cfg_en && (s_if.cfg_idx == IW'(i))) ||
             ((w_do_button || w_do_snooze || w_do_timeout) && (r_active == IW'(i))))
            w_pend_nxt[i] = 1'b0;
      end
   end

   // Lowest index wins: scan downward so the last hit is the smallest.
   always_comb begin
      w_sel = '0;
      for (int i = NUM_ALARMS - 1; i >= 0; i--)
         if (r_pending[i]) w_sel = IW'(i);
   end

   always_ff @(posedge MCLK or negedge RESET_N) begin
      if (!RESET_N) begin
         r_state      <= S_IDLE;
         for (int i = 0; i < NUM_ALARMS; i++) r_slot_time[i] <= '0;
         r_slot_en    <= '0;
         r_pending    <= '0;
         r_active     <= '0;
         r_active_idx <= '0;
         r_snz_cnt    <= '0;
         r_tcnt       <= '0;
         r_ringing    <= 1'b0;
         r_game       <= 1'b0;
         r_missed     <= 1'b0;
      end else begin
         r_pending <= w_pend_nxt;
         // A config write to the slot being snoozed overrides the snooze update.
         for (int i = 0; i < NUM_ALARMS; i++) begin
            if (w_do_snooze && (r_active == IW'(i)))
               r_slot_time[i] <= w_snz_time;
            if (w_cfg_ok && (s_if.cfg_idx == IW'(i))) begin
               r_slot_time[i] <= s_if.cfg_time;
               r_slot_en[i]   <= s_if.cfg_en;
            end
         end

         r_ringing    <= (r_state == S_RING);
         r_game       <= (r_state == S_GAME);
         r_active_idx <= (r_state != S_IDLE) ? r_active : '0;
         r_missed     <= w_do_timeout;

         case (r_state)
            S_IDLE: begin
               if (|r_pending) begin
                  r_active <= w_sel;
                  r_tcnt   <= '0;
                  r_state  <= S_RING;
               end
            end
            S_RING: begin
               if (s_if.tick_1s) r_tcnt <= w_tcnt_inc;
               if (w_kill) begin
                  r_state <= S_IDLE;
               end else if (w_do_button) begin
                  r_state <= S_GAME;
               end else if (w_do_snooze) begin
                  r_snz_cnt <= r_snz_cnt + 4'd1;
                  r_state   <= S_IDLE;
               end else if (w_do_timeout) begin
                  r_snz_cnt <= '0;
                  r_state   <= S_IDLE;
               end
            end
            S_GAME: begin
               if (s_if.minigame_done) begin
                  r_snz_cnt <= '0;
                  r_state   <= S_IDLE;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign s_if.alarm_ringing   = r_ringing;
   assign s_if.minigame_enable = r_game;
   assign s_if.active_idx      = r_active_idx;
   assign s_if.pending         = r_pending;
   assign s_if.missed          = r_missed;
endmodule

// File: tb/tb_alarm_scheduler.sv
// Purpose : directed self-checking bench for alarm_scheduler with an expected-slot scoreboard.
// Latency : inputs driven 1 ns after MCLK rise, outputs sampled at the same point.
// Backpr. : none; every wait is bounded by a cycle budget.
module tb_alarm_scheduler;
   logic MCLK;
   logic RESET_N;
   int   n_assert = 0;
   int   n_fail   = 0;
   int   sb[$];
   int   lat;

   alarm_scheduler_if #(.NUM_ALARMS(4)) bus ();

   alarm_scheduler #(
      .NUM_ALARMS(4), .SNOOZE_MIN(5), .MAX_SNOOZE(3), .RING_TIMEOUT(60)
   ) dut (
      .MCLK(MCLK), .RESET_N(RESET_N), .s_if(bus)
   );

   initial MCLK = 1'b0;
   always #5 MCLK = ~MCLK;

   task automatic step();
      @(posedge MCLK);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic cfg_write(input logic [1:0] idx, input logic [15:0] t, input logic en);
      bus.cfg_we = 1'b1; bus.cfg_idx = idx; bus.cfg_time = t; bus.cfg_en = en;
      step();
      bus.cfg_we = 1'b0;
   endtask

   task automatic tick_at(input logic [15:0] t);
      bus.cur_time = t; bus.tick_1s = 1'b1;
      step();
      bus.tick_1s = 1'b0;
   endtask

   task automatic press_button();
      bus.button = 1'b1; step(); bus.button = 1'b0; step();
   endtask

   task automatic press_snooze();
      bus.snooze_btn = 1'b1; step(); bus.snooze_btn = 1'b0; step();
   endtask

   task automatic game_done();
      bus.minigame_done = 1'b1; step(); bus.minigame_done = 1'b0; step();
   endtask

   // Waits (bounded) for alarm_ringing, then checks the served slot against the scoreboard.
   task automatic wait_ring(input string tag, output int cycles);
      int exp_idx;
      cycles = 0;
      while (!bus.alarm_ringing && cycles < 6) begin
         step();
         cycles++;
      end
      chk({tag, "_ringing"}, 32'(bus.alarm_ringing), 32'd1);
      n_assert++;
      assert (sb.size() != 0) else begin
         n_fail++;
         $error("FAIL %s_scoreboard: observed ring with no expected slot queued, expected an entry", tag);
      end
      if (sb.size() != 0) begin
         exp_idx = sb.pop_front();
         chk({tag, "_active_idx"}, 32'(bus.active_idx), 32'(exp_idx));
      end
   endtask

   initial begin
      RESET_N = 1'b0;
      bus.tick_1s = 1'b0; bus.cur_time = '0; bus.cfg_we = 1'b0; bus.cfg_idx = '0;
      bus.cfg_time = '0; bus.cfg_en = 1'b0; bus.button = 1'b0; bus.snooze_btn = 1'b0;
      bus.minigame_done = 1'b0;
      step(); step();
      RESET_N = 1'b1;
      step();
      chk("rst_ringing", 32'(bus.alarm_ringing), 32'd0);
      chk("rst_game",    32'(bus.minigame_enable), 32'd0);
      chk("rst_pending", 32'(bus.pending), 32'd0);
      chk("rst_idx",     32'(bus.active_idx), 32'd0);
      chk("rst_missed",  32'(bus.missed), 32'd0);

      // Single slot: 12:30 on slot 1, ring -> game -> idle.
      cfg_write(2'd1, 16'h1230, 1'b1);
      sb.push_back(1);
      tick_at(16'h1230);
      chk("t1_pending", 32'(bus.pending), 32'b0010);
      wait_ring("t1", lat);
      chk("t1_latency", 32'(lat), 32'd2);
      press_button();
      chk("t1_game", 32'(bus.minigame_enable), 32'd1);
      chk("t1_ring_off", 32'(bus.alarm_ringing), 32'd0);
      tick_at(16'h1230);
      chk("t1_served_match_ignored", 32'(bus.pending), 32'd0);
      game_done();
      chk("t1_idle_game", 32'(bus.minigame_enable), 32'd0);
      chk("t1_idle_ring", 32'(bus.alarm_ringing), 32'd0);
      chk("t1_idle_idx", 32'(bus.active_idx), 32'd0);

      // Two slots matching on the same tick: lowest index first, second follows without a tick.
      cfg_write(2'd0, 16'h0500, 1'b1);
      cfg_write(2'd2, 16'h0500, 1'b1);
      sb.push_back(0);
      sb.push_back(2);
      tick_at(16'h0500);
      chk("t2_pending", 32'(bus.pending), 32'b0101);
      wait_ring("t2a", lat);
      press_button();
      game_done();
      chk("t2_gap_ring", 32'(bus.alarm_ringing), 32'd0);
      wait_ring("t2b", lat);
      press_button();
      game_done();

      // Snooze wraps 57:10 -> 02:10, then 07:10, 12:10; the fourth snooze is refused.
      cfg_write(2'd3, 16'h5710, 1'b1);
      sb.push_back(3);
      tick_at(16'h5710);
      wait_ring("t3a", lat);
      press_snooze();
      chk("t3_snz_ring_off", 32'(bus.alarm_ringing), 32'd0);
      chk("t3_snz_pending", 32'(bus.pending), 32'd0);
      tick_at(16'h5710);
      chk("t3_old_time_gone", 32'(bus.pending), 32'd0);
      sb.push_back(3);
      tick_at(16'h0210);
      chk("t3_wrap_0210", 32'(bus.pending), 32'b1000);
      wait_ring("t3b", lat);
      press_snooze();
      sb.push_back(3);
      tick_at(16'h0710);
      wait_ring("t3c", lat);
      press_snooze();
      sb.push_back(3);
      tick_at(16'h1210);
      wait_ring("t3d", lat);
      press_snooze();
      chk("t3_4th_snz_ring", 32'(bus.alarm_ringing), 32'd1);
      chk("t3_4th_snz_pend", 32'(bus.pending), 32'b1000);
      press_button();
      game_done();

      // Ring timeout: missed pulses on the 60th tick only.
      sb.push_back(3);
      tick_at(16'h1210);
      wait_ring("t4", lat);
      for (int k = 0; k < 59; k++) tick_at(16'h0000);
      chk("t4_missed_early", 32'(bus.missed), 32'd0);
      chk("t4_still_ring", 32'(bus.alarm_ringing), 32'd1);
      tick_at(16'h0000);
      chk("t4_missed", 32'(bus.missed), 32'd1);
      chk("t4_pend_clr", 32'(bus.pending), 32'd0);
      step();
      chk("t4_missed_pulse", 32'(bus.missed), 32'd0);
      chk("t4_ring_off", 32'(bus.alarm_ringing), 32'd0);

      // button+snooze together: game wins, time unchanged; invalid BCD write dropped; disable kills ring.
      sb.push_back(3);
      tick_at(16'h1210);
      wait_ring("t5a", lat);
      bus.button = 1'b1; bus.snooze_btn = 1'b1;
      step();
      bus.button = 1'b0; bus.snooze_btn = 1'b0;
      step();
      chk("t5_both_game", 32'(bus.minigame_enable), 32'd1);
      game_done();
      cfg_write(2'd3, 16'h6A00, 1'b1);
      sb.push_back(3);
      tick_at(16'h1210);
      chk("t5_time_kept", 32'(bus.pending), 32'b1000);
      wait_ring("t5b", lat);
      cfg_write(2'd3, 16'h1210, 1'b0);
      chk("t5_kill_no_miss", 32'(bus.missed), 32'd0);
      step();
      chk("t5_kill_ring_off", 32'(bus.alarm_ringing), 32'd0);
      chk("t5_kill_pending", 32'(bus.pending), 32'd0);

      // Asynchronous reset in the middle of GAME.
      sb.push_back(1);
      tick_at(16'h1230);
      wait_ring("t6", lat);
      press_button();
      tick_at(16'h0500);
      chk("t6_game", 32'(bus.minigame_enable), 32'd1);
      chk("t6_pending", 32'(bus.pending), 32'b0101);
      #3;
      RESET_N = 1'b0;
      #1;
      chk("t6_rst_game", 32'(bus.minigame_enable), 32'd0);
      chk("t6_rst_ring", 32'(bus.alarm_ringing), 32'd0);
      chk("t6_rst_pending", 32'(bus.pending), 32'd0);
      chk("t6_rst_missed", 32'(bus.missed), 32'd0);
      #2;
      RESET_N = 1'b1;
      step();
      tick_at(16'h1230);
      chk("t6_no_match", 32'(bus.pending), 32'd0);
      step(); step();
      chk("t6_no_ring", 32'(bus.alarm_ringing), 32'd0);
      chk("sb_drained", 32'(sb.size()), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule

// File: doc/alarm_scheduler.md
Name: alarm_scheduler

Overview:
Multi-slot alarm controller that owns the alarm ringer and minigame resource and sequences them for up to NUM_ALARMS programmable alarms.
It compares each enabled slot against the current BCD mm:ss time once per second and latches matches as pending. It arbitrates pending alarms onto the single ring/minigame path and sequences RING -> GAME -> IDLE, with snooze re-arming and a ring timeout.

Parameters:
NUM_ALARMS, 4, number of alarm slots (2..8); idx width IW = clog2(NUM_ALARMS).
SNOOZE_MIN, 5, minutes added to a slot on snooze (1..9).
MAX_SNOOZE, 3, snoozes allowed per ring episode before snooze_btn is ignored.
RING_TIMEOUT, 60, seconds of unanswered ringing before the alarm is dropped as missed (1..255).

Ports:
MCLK  in  1  system clock
RESET_N  in  1  asynchronous active-low reset
tick_1s  in  1  one-cycle pulse at each seconds boundary, synchronous to MCLK
cur_time  in  16  current time BCD {min10,min01,sec10,sec01}
cfg_we  in  1  slot write strobe
cfg_idx  in  IW  slot to write
cfg_time  in  16  alarm time BCD, same packing as cur_time
cfg_en  in  1  slot enable written with cfg_time
button  in  1  dismiss/accept pulse (debounced, one cycle)
snooze_btn  in  1  snooze pulse (debounced, one cycle)
minigame_done  in  1  minigame completion pulse
alarm_ringing  out  1  high while in RING
minigame_enable  out  1  high while in GAME
active_idx  out  IW  slot being served (valid in RING/GAME, else 0)
pending  out  NUM_ALARMS  latched matched-but-unserved slots
missed  out  1  one-cycle pulse when a ring times out

Behaviour:
- Reset: all slots disabled, all slot times 00:00, pending=0, snooze_cnt=0, timeout counter=0, state IDLE. All outputs 0.
- Config write: on cfg_we, store cfg_time/cfg_en into slot cfg_idx. The write is dropped if any digit is invalid (min10>5, min01>9, sec10>5, sec01>9).
- Writing cfg_en=0 to a slot clears its pending bit.
- Writing cfg_en=0 to active_idx while in RING returns to IDLE the next cycle, with no missed pulse. In GAME the write has no effect on the state.
- Match: on a cycle with tick_1s=1, every enabled slot whose time equals cur_time sets its pending bit. No match is evaluated without tick_1s, so each slot fires at most once per second.
- A match that lands on the slot currently being served (RING/GAME) is ignored.
- States:
  IDLE: if pending!=0, select the lowest-index pending slot and latch it into active_idx. Clear the timeout counter and go to RING next cycle.
  RING: alarm_ringing=1. Each tick_1s increments the timeout counter. Transitions are tested in priority order:
    (1) button -> clear pending[active], go to GAME.
    (2) snooze_btn with snooze_cnt<MAX_SNOOZE -> slot minutes += SNOOZE_MIN in BCD, modulo 60 (e.g. 57+5=02); seconds unchanged. Then snooze_cnt++, clear pending[active], go to IDLE.
    (3) snooze_btn with snooze_cnt==MAX_SNOOZE -> ignored.
    (4) counter reaches RING_TIMEOUT -> missed=1 for one cycle, clear pending[active], snooze_cnt=0, go to IDLE.
  GAME: minigame_enable=1. On minigame_done, set snooze_cnt=0 and go to IDLE. button and snooze_btn are ignored.
- button and snooze_btn in the same cycle: button wins and the slot time is unchanged.
- Pending match and clear on the same cycle for the same slot: the clear wins.
- Outputs are registered from state, so they assert one cycle after the state is entered.
- Worst case, match tick to alarm_ringing high is 3 cycles: pending set, IDLE selects, RING output.
- The snooze counter is shared: it counts per episode, not per slot.
- Reset mid-operation returns immediately to the reset values, including slot contents.

Test Plan:
- Program slot 1 = 12:30 enabled, drive cur_time 12:30 with tick_1s -> pending=0010 and alarm_ringing=1 within 3 cycles, active_idx=1. Then button -> minigame_enable=1, alarm_ringing=0. Then minigame_done -> IDLE, all outputs 0.
- Slots 0 and 2 both set to 05:00, matched on the same tick -> slot 0 served first. After slot 0 completes, slot 2 rings with active_idx=2 and no new tick required.
- Slot 3 = 57:10, ring then snooze -> slot 3 time reads 02:10, alarm_ringing=0. The 4th consecutive snooze (MAX_SNOOZE=3) is ignored and the bench stays in RING.
- Ring with no input for 60 ticks -> missed pulses for exactly 1 cycle on the 60th tick, pending bit cleared, state IDLE.
- button and snooze_btn together in RING -> GAME entered, slot time unchanged. A cfg_time=6A:00 write -> dropped, slot keeps its old value.
- Assert RESET_N low mid-GAME -> minigame_enable, alarm_ringing, pending and missed drop to 0 asynchronously. After release, the old alarm time no longer matches because the slots are disabled.
